// File: rtl/whack_game_ctrl_pkg.sv
// Shared definitions for the whack-a-mole game controller:
// state encodings, board geometry, score width and the hole-to-LED mapping.
package game_pkg;

  typedef enum logic [1:0] {
    INITIAL = 2'b00,
    GAME    = 2'b01,
    FINAL   = 2'b10
  } state_t;

  localparam int NUM_HOLES = 9;
  localparam int SCORE_W   = 8;

  // Hole n (1..NUM_HOLES) is shown on led[16-n]; the low LEDs stay dark.
  function automatic logic [15:0] led_map(input logic [NUM_HOLES-1:0] moles);
    logic [15:0] leds;
    leds = '0;
    for (int n = 1; n <= NUM_HOLES; n++) begin
      leds[16-n] = moles[n-1];
    end
    return leds;
  endfunction

endpackage

// File: rtl/whack_game_ctrl_if.sv
// Front-end / display bundle of the game controller. The master side drives
// the debounced start pulse and keypad strobes; the slave side (the
// controller) returns state, LEDs, hit vector, score and round information.
interface whack_game_ctrl_if;
  import game_pkg::*;

  logic                 start;
  logic                 key_valid;
  logic [3:0]           key_num;
  logic [1:0]           state;
  logic [15:0]          led;
  logic [NUM_HOLES-1:0] hit;
  logic [SCORE_W-1:0]   score;
  logic [4:0]           round;
  logic                 round_tick;

  modport master (
    output start, key_valid, key_num,
    input  state, led, hit, score, round, round_tick
  );

  modport slave (
    input  start, key_valid, key_num,
    output state, led, hit, score, round, round_tick
  );

endinterface

// File: rtl/whack_game_ctrl_mole_lfsr.sv
// Mole pattern source: 16-bit Fibonacci LFSR (taps 16,14,13,11) that steps
// whenever advance is high. The low nine bits form the mole pattern; an
// all-zero pattern is replaced by hole 1 so every round shows a mole.
module mole_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       advance,
  output logic [8:0] pattern
);

  logic [15:0] lfsr_q;
  logic        feedback;

  assign feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // Shift register, reloaded with the seed on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else if (advance) begin
      lfsr_q <= {lfsr_q[14:0], feedback};
    end
  end

  // Pattern extraction with empty-board substitution.
  always_comb begin
    pattern = lfsr_q[8:0];
    if (pattern == 9'd0) begin
      pattern = 9'b000000001;
    end
  end

endmodule

// File: rtl/whack_game_ctrl.sv
// Lab6 whack-a-mole sequencer: INITIAL/GAME/FINAL control, round timing,
// mole pattern loading and hit/score bookkeeping. Every output is a register.
// Optional macro HIT_PENALTY_EN: a valid press on an unlit or already-hit
// hole during GAME costs one point (floored at zero).
module whack_game_ctrl
  import game_pkg::*;
#(
  parameter int          TICKS_PER_ROUND = 100_000_000,
  parameter int          ROUNDS          = 30,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input logic             clk,
  input logic             rst_n,
  whack_game_ctrl_if.slave bus
);

  localparam int               TICK_W     = (TICKS_PER_ROUND > 1) ? $clog2(TICKS_PER_ROUND) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_ROUND - 1);
  localparam logic [4:0]       ROUND_LAST = 5'(ROUNDS - 1);

  state_t               state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [4:0]           round_q, round_d;
  logic [NUM_HOLES-1:0] pattern_q, pattern_d;
  logic [NUM_HOLES-1:0] hit_q, hit_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [15:0]          led_q, led_d;
  logic                 round_tick_q, round_tick_d;
  logic [NUM_HOLES-1:0] lfsr_pattern;
  logic [NUM_HOLES-1:0] key_mask;
  logic                 key_ok;
  logic                 wrap;

  mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (1'b1),
    .pattern (lfsr_pattern)
  );

  // Game registers; reset clears every visible output at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= INITIAL;
      tick_q       <= '0;
      round_q      <= '0;
      pattern_q    <= '0;
      hit_q        <= '0;
      score_q      <= '0;
      led_q        <= '0;
      round_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      round_q      <= round_d;
      pattern_q    <= pattern_d;
      hit_q        <= hit_d;
      score_q      <= score_d;
      led_q        <= led_d;
      round_tick_q <= round_tick_d;
    end
  end

  // Next-state logic: state transitions, round timing, key scoring, LED image.
  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    round_d      = round_q;
    pattern_d    = pattern_q;
    hit_d        = hit_q;
    score_d      = score_q;
    round_tick_d = 1'b0;
    key_ok       = bus.key_valid && (bus.key_num >= 4'd1) && (bus.key_num <= 4'd9);
    key_mask     = '0;
    if (key_ok) begin
      key_mask = NUM_HOLES'(1) << (bus.key_num - 4'd1);
    end
    wrap = (tick_q == TICK_LAST);

    case (state_q)
      INITIAL: begin
        tick_d = '0;
        if (bus.start) begin
          state_d   = GAME;
          pattern_d = lfsr_pattern;
          hit_d     = '0;
          score_d   = '0;
          round_d   = '0;
        end
      end
      GAME: begin
        if (wrap) begin
          tick_d       = '0;
          round_tick_d = 1'b1;
          hit_d        = '0;
          pattern_d    = lfsr_pattern;
          if (round_q == ROUND_LAST) begin
            state_d = FINAL;
          end else begin
            round_d = round_q + 5'd1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
          if (key_ok) begin
            if ((pattern_q & ~hit_q & key_mask) != '0) begin
              hit_d = hit_q | key_mask;
              if (score_q != '1) begin
                score_d = score_q + 1'b1;
              end
            end
`ifdef HIT_PENALTY_EN
            else if (score_q != '0) begin
              score_d = score_q - 1'b1;
            end
`endif
          end
        end
      end
      FINAL: begin
        tick_d = '0;
        hit_d  = '0;
        if (bus.start) begin
          state_d = INITIAL;
        end
      end
      default: begin
        state_d = INITIAL;
      end
    endcase

    case (state_d)
      GAME:    led_d = led_map(pattern_d & ~hit_d);
      FINAL:   led_d = 16'hFFFF;
      default: led_d = 16'h0000;
    endcase
  end

  assign bus.state      = state_q;
  assign bus.led        = led_q;
  assign bus.hit        = hit_q;
  assign bus.score      = score_q;
  assign bus.round      = round_q;
  assign bus.round_tick = round_tick_q;

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Self-checking bench for whack_game_ctrl with an 8-tick, 3-round game.
// Each driven cycle pushes the predicted outputs into a scoreboard queue;
// the scenario tasks pop and compare once the DUT has clocked.
module tb_whack_game_ctrl;
  import game_pkg::*;

  localparam int          TPR  = 8;
  localparam int          NR   = 3;
  localparam logic [15:0] SEED = 16'hACE1;
`ifdef HIT_PENALTY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  whack_game_ctrl_if bus();

  whack_game_ctrl #(
    .TICKS_PER_ROUND (TPR),
    .ROUNDS          (NR),
    .LFSR_SEED       (SEED)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [40:0] sb[$];
  logic [40:0] exp_v;

  // Reference LFSR, stepping every clock like the board's pattern source.
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= SEED;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  int         m_state, m_tick, m_round, m_score, game_cycles, hit_hole;
  logic [8:0] m_pat, m_hit;
  logic       m_rt;

  function automatic logic [40:0] outs();
    return {bus.state, bus.led, bus.hit, bus.score, bus.round, bus.round_tick};
  endfunction

  function automatic logic [15:0] exp_led(int st, logic [8:0] pat, logic [8:0] h);
    logic [15:0] l;
    l = 16'h0000;
    if (st == 1) begin
      for (int n = 1; n <= 9; n++) l[16-n] = pat[n-1] & ~h[n-1];
    end else if (st == 2) begin
      l = 16'hFFFF;
    end
    return l;
  endfunction

  task automatic model_reset();
    m_state = 0; m_tick = 0; m_round = 0; m_score = 0;
    m_pat = '0; m_hit = '0; m_rt = 1'b0; game_cycles = 0;
  endtask

  // Drive one cycle of inputs, advance the reference model and queue its prediction.
  task automatic drive_cycle(input logic s, input logic kv, input logic [3:0] kn);
    logic [8:0] p, nh, np;
    int ns, nt, nr, nsc;
    logic rt;
    bus.start = s; bus.key_valid = kv; bus.key_num = kn;
    p = m_lfsr[8:0];
    if (p == 9'd0) p = 9'd1;
    ns = m_state; nt = m_tick; nr = m_round; nsc = m_score;
    nh = m_hit; np = m_pat; rt = 1'b0;
    case (m_state)
      0: begin
        nt = 0;
        if (s) begin ns = 1; np = p; nh = '0; nsc = 0; nr = 0; end
      end
      1: begin
        game_cycles++;
        if (m_tick == TPR - 1) begin
          nt = 0; rt = 1'b1; nh = '0; np = p;
          if (m_round == NR - 1) ns = 2;
          else nr = m_round + 1;
        end else begin
          nt = m_tick + 1;
          if (kv && kn >= 1 && kn <= 9) begin
            if (m_pat[kn-1] && !m_hit[kn-1]) begin
              nh[kn-1] = 1'b1;
              if (m_score != 255) nsc = m_score + 1;
            end else if (PEN && m_score != 0) begin
              nsc = m_score - 1;
            end
          end
        end
      end
      default: begin
        nt = 0; nh = '0;
        if (s) ns = 0;
      end
    endcase
    if (m_state == 0 && ns == 1) game_cycles = 0;
    m_state = ns; m_tick = nt; m_round = nr; m_score = nsc;
    m_hit = nh; m_pat = np; m_rt = rt;
    sb.push_back({2'(m_state), exp_led(m_state, m_pat, m_hit), m_hit,
                  8'(m_score), 5'(m_round), m_rt});
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.key_valid = 1'b0; bus.key_num = 4'd0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.key_valid = 1'b0; bus.key_num = 4'd0;
    rst_n = 1'b0;
    model_reset();
    #12;
    checks++;
    if (bus.state !== 2'b00) begin errors++; $display("[TB] FAIL reset_state: got %b want 00", bus.state); end
    checks++;
    if (bus.led !== 16'h0000) begin errors++; $display("[TB] FAIL reset_led: got %h want 0000", bus.led); end
    checks++;
    if ({bus.hit, bus.score, bus.round, bus.round_tick} !== 23'd0) begin
      errors++; $display("[TB] FAIL reset_counters: got %h want 0", {bus.hit, bus.score, bus.round, bus.round_tick});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, (i == 2), (i == 2) ? 4'd12 : 4'd3);
      exp_v = sb.pop_front(); checks++;
      if (outs() !== exp_v) begin errors++; $display("[TB] FAIL idle_%0d: got %h want %h", i, outs(), exp_v); end
    end
  endtask

  task automatic test_start();
    drive_cycle(1'b1, 1'b0, 4'd0);
    exp_v = sb.pop_front(); checks++;
    if (outs() !== exp_v) begin errors++; $display("[TB] FAIL start_entry: got %h want %h", outs(), exp_v); end
    checks++;
    if (bus.state !== 2'b01) begin errors++; $display("[TB] FAIL start_state: got %b want 01", bus.state); end
    checks++;
    if (bus.led[15:7] === 9'd0) begin errors++; $display("[TB] FAIL start_moles: got %h want nonzero", bus.led[15:7]); end
  endtask

  task automatic test_hit();
    hit_hole = 1;
    for (int n = 9; n >= 1; n--) if (m_pat[n-1] && !m_hit[n-1]) hit_hole = n;
    drive_cycle(1'b0, 1'b1, 4'(hit_hole));
    exp_v = sb.pop_front(); checks++;
    if (outs() !== exp_v) begin errors++; $display("[TB] FAIL hit_accept: got %h want %h", outs(), exp_v); end
    checks++;
    if (bus.score !== 8'd1) begin errors++; $display("[TB] FAIL hit_score: got %0d want 1", bus.score); end
    checks++;
    if (bus.hit[hit_hole-1] !== 1'b1 || bus.led[16-hit_hole] !== 1'b0) begin
      errors++; $display("[TB] FAIL hit_bits: hit=%b led=%h hole %0d", bus.hit, bus.led, hit_hole);
    end
  endtask

  task automatic test_miss();
    int miss_hole, sc_before;
    logic [8:0] hit_before;
    miss_hole = hit_hole;
    for (int n = 1; n <= 9; n++) if (!m_pat[n-1]) miss_hole = n;
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b0, 1'b1, 4'(miss_hole));
      exp_v = sb.pop_front(); checks++;
      if (outs() !== exp_v) begin errors++; $display("[TB] FAIL miss_%0d: got %h want %h", i, outs(), exp_v); end
      checks++;
      if (bus.score !== (PEN ? 8'd0 : 8'd1)) begin
        errors++; $display("[TB] FAIL miss_score_%0d: got %0d want %0d", i, bus.score, PEN ? 0 : 1);
      end
    end
    drive_cycle(1'b0, 1'b1, 4'(hit_hole));
    exp_v = sb.pop_front(); checks++;
    if (outs() !== exp_v) begin errors++; $display("[TB] FAIL repeat_press: got %h want %h", outs(), exp_v); end
    sc_before = m_score;
    hit_before = m_hit;
    drive_cycle(1'b0, 1'b1, 4'd0);
    exp_v = sb.pop_front(); checks++;
    if (bus.score !== 8'(sc_before) || bus.hit !== hit_before || outs() !== exp_v) begin
      errors++; $display("[TB] FAIL key_zero: got %h want %h", outs(), exp_v);
    end
    drive_cycle(1'b0, 1'b1, 4'd12);
    exp_v = sb.pop_front(); checks++;
    if (bus.score !== 8'(sc_before) || bus.hit !== hit_before || outs() !== exp_v) begin
      errors++; $display("[TB] FAIL key_twelve: got %h want %h", outs(), exp_v);
    end
  endtask

  task automatic test_wrap_collision();
    int sc, rd, n_key;
    for (int i = 0; i < 2 * TPR && m_tick != TPR - 1; i++) begin
      drive_cycle(1'b0, 1'b0, 4'd0);
      exp_v = sb.pop_front(); checks++;
      if (outs() !== exp_v) begin errors++; $display("[TB] FAIL pre_wrap_%0d: got %h want %h", i, outs(), exp_v); end
    end
    checks++;
    if (m_tick != TPR - 1) begin errors++; $display("[TB] FAIL wrap_timeout: tick %0d want %0d", m_tick, TPR - 1); end
    n_key = 1;
    for (int n = 9; n >= 1; n--) if (m_pat[n-1] && !m_hit[n-1]) n_key = n;
    sc = m_score;
    rd = m_round;
    drive_cycle(1'b0, 1'b1, 4'(n_key));
    exp_v = sb.pop_front(); checks++;
    if (outs() !== exp_v) begin errors++; $display("[TB] FAIL wrap_cycle: got %h want %h", outs(), exp_v); end
    checks++;
    if (bus.round_tick !== 1'b1 || bus.hit !== 9'd0) begin
      errors++; $display("[TB] FAIL wrap_tick: round_tick=%b hit=%b want 1 and 0", bus.round_tick, bus.hit);
    end
    checks++;
    if (bus.score !== 8'(sc) || bus.round !== 5'(rd + 1)) begin
      errors++; $display("[TB] FAIL wrap_counts: score=%0d round=%0d want %0d %0d", bus.score, bus.round, sc, rd + 1);
    end
    drive_cycle(1'b0, 1'b0, 4'd0);
    exp_v = sb.pop_front(); checks++;
    if (outs() !== exp_v || bus.round_tick !== 1'b0) begin
      errors++; $display("[TB] FAIL wrap_pulse_end: got %h want %h", outs(), exp_v);
    end
  endtask

  task automatic test_start_ignored();
    drive_cycle(1'b1, 1'b0, 4'd0);
    exp_v = sb.pop_front(); checks++;
    if (outs() !== exp_v || bus.state !== 2'b01) begin
      errors++; $display("[TB] FAIL start_in_game: got %h want %h", outs(), exp_v);
    end
  endtask

  task automatic test_final();
    int sc;
    sc = m_score;
    for (int i = 0; i < 4 * TPR * NR && game_cycles < TPR * NR; i++) begin
      drive_cycle(1'b0, 1'b0, 4'd0);
      exp_v = sb.pop_front(); checks++;
      if (outs() !== exp_v) begin errors++; $display("[TB] FAIL run_%0d: got %h want %h", i, outs(), exp_v); end
    end
    checks++;
    if (bus.state !== 2'b10 || bus.led !== 16'hFFFF) begin
      errors++; $display("[TB] FAIL final_entry: state=%b led=%h want 10 ffff", bus.state, bus.led);
    end
    checks++;
    if (bus.score !== 8'(sc)) begin errors++; $display("[TB] FAIL final_score: got %0d want %0d", bus.score, sc); end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, (i == 1), 4'd2);
      exp_v = sb.pop_front(); checks++;
      if (outs() !== exp_v) begin errors++; $display("[TB] FAIL final_hold_%0d: got %h want %h", i, outs(), exp_v); end
    end
    drive_cycle(1'b1, 1'b0, 4'd0);
    exp_v = sb.pop_front(); checks++;
    if (outs() !== exp_v || bus.state !== 2'b00 || bus.score !== 8'(sc)) begin
      errors++; $display("[TB] FAIL final_to_idle: got %h want %h", outs(), exp_v);
    end
    drive_cycle(1'b1, 1'b0, 4'd0);
    exp_v = sb.pop_front(); checks++;
    if (outs() !== exp_v || bus.score !== 8'd0 || bus.round !== 5'd0) begin
      errors++; $display("[TB] FAIL regame: got %h want %h", outs(), exp_v);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4 * TPR && !(m_round == 1 && m_tick == 3); i++) begin
      drive_cycle(1'b0, (i == 2), 4'd5);
      exp_v = sb.pop_front(); checks++;
      if (outs() !== exp_v) begin errors++; $display("[TB] FAIL round2_%0d: got %h want %h", i, outs(), exp_v); end
    end
    checks++;
    if (bus.state !== 2'b01 || bus.round !== 5'd1) begin
      errors++; $display("[TB] FAIL round2_reach: state=%b round=%0d want 01 1", bus.state, bus.round);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== 41'd0) begin errors++; $display("[TB] FAIL async_reset: got %h want 0", outs()); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive_cycle(1'b1, 1'b0, 4'd0);
    exp_v = sb.pop_front(); checks++;
    if (outs() !== exp_v) begin errors++; $display("[TB] FAIL post_reset_start: got %h want %h", outs(), exp_v); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_idle();
    test_start();
    test_hit();
    test_miss();
    test_wrap_collision();
    test_start_ignored();
    test_final();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
